// File: rtl/sar_pkg.sv
// Shared types and limits for the SAR scan controller: FSM states,
// the channel-select width helper and legal parameter ranges.
package sar_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 12;
    localparam int NCH_MIN   = 1;
    localparam int NCH_MAX   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_TRIAL,
        ST_DECIDE,
        ST_DONE
    } sar_state_e;

    // A single-channel build still gets a 1-bit mux select.
    function automatic int chw_of(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/sar_chan_pick.sv
// Combinational picker: lowest set bit of mask_i at or above index from_i.
// from_i is one bit wider than an index so "past the last channel" is representable.
module sar_chan_pick
    import sar_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CHW = chw_of(NCH)
) (
    input  logic [NCH-1:0] mask_i,
    input  logic [CHW:0]   from_i,
    output logic           found_o,
    output logic [CHW-1:0] idx_o
);

    // Scan downwards so the lowest qualifying bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i >= int'(from_i))) begin
                found_o = 1'b1;
                idx_o   = CHW'(i);
            end
        end
    end

endmodule

// File: rtl/sar_scan_ctrl.sv
// Multi-channel SAR ADC sequencer: per channel a track phase, then one
// TRIAL/DECIDE pair per bit MSB first, then a one-cycle DONE with the result.
module sar_scan_ctrl
    import sar_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NCH        = 4,
    parameter  int SAMPLE_CYC = 4,
    localparam int CHW        = chw_of(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cont,
    input  logic [NCH-1:0]   ch_mask,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [CHW-1:0]   ch_sel,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CHW-1:0]   result_ch
);

    localparam int BW  = $clog2(WIDTH);
    localparam int SCW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_param
        $error("sar_scan_ctrl: WIDTH or NCH out of range");
    end

    sar_state_e       state_q, state_d;
    logic [NCH-1:0]   scan_q, scan_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [CHW-1:0]   res_ch_q, res_ch_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [SCW-1:0]   scnt_q, scnt_d;

    logic [WIDTH-1:0] trial;
    logic [NCH-1:0]   scan_rest;
    logic [CHW:0]     from_nxt;
    logic             nxt_found, new_found;
    logic [CHW-1:0]   nxt_idx, new_idx;

    assign trial     = code_q | (WIDTH'(1) << bit_q);
    assign scan_rest = scan_q & ~(NCH'(1) << ch_q);
    assign from_nxt  = {1'b0, ch_q} + (CHW + 1)'(1);

    // Next pending channel of the current scan.
    sar_chan_pick #(.NCH(NCH)) u_pick_nxt (
        .mask_i  (scan_rest),
        .from_i  (from_nxt),
        .found_o (nxt_found),
        .idx_o   (nxt_idx)
    );

    // First channel of a fresh scan, taken from the live mask.
    sar_chan_pick #(.NCH(NCH)) u_pick_new (
        .mask_i  (ch_mask),
        .from_i  ('0),
        .found_o (new_found),
        .idx_o   (new_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            scan_q   <= '0;
            ch_q     <= '0;
            res_ch_q <= '0;
            code_q   <= '0;
            res_q    <= '0;
            bit_q    <= '0;
            scnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            scan_q   <= scan_d;
            ch_q     <= ch_d;
            res_ch_q <= res_ch_d;
            code_q   <= code_d;
            res_q    <= res_d;
            bit_q    <= bit_d;
            scnt_q   <= scnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        scan_d   = scan_q;
        ch_d     = ch_q;
        res_ch_d = res_ch_q;
        code_d   = code_q;
        res_d    = res_q;
        bit_d    = bit_q;
        scnt_d   = scnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start && new_found) begin
                    state_d = ST_SAMPLE;
                    scan_d  = ch_mask;
                    ch_d    = new_idx;
                    scnt_d  = '0;
                end
            end
            ST_SAMPLE: begin
                if (scnt_q == SCW'(SAMPLE_CYC - 1)) begin
                    state_d = ST_TRIAL;
                    code_d  = '0;
                    bit_d   = BW'(WIDTH - 1);
                end else begin
                    scnt_d = scnt_q + SCW'(1);
                end
            end
            ST_TRIAL: state_d = ST_DECIDE;
            ST_DECIDE: begin
                // The trial bit survives only if Vin is at or above the DAC level.
                if (cmp_in) code_d = trial;
                if (bit_q == '0) begin
                    state_d  = ST_DONE;
                    res_d    = cmp_in ? trial : code_q;
                    res_ch_d = ch_q;
                end else begin
                    state_d = ST_TRIAL;
                    bit_d   = bit_q - BW'(1);
                end
            end
            ST_DONE: begin
                scnt_d = '0;
                if (nxt_found) begin
                    state_d = ST_SAMPLE;
                    scan_d  = scan_rest;
                    ch_d    = nxt_idx;
                end else if (cont && new_found) begin
                    state_d = ST_SAMPLE;
                    scan_d  = ch_mask;
                    ch_d    = new_idx;
                end else begin
                    state_d = ST_IDLE;
                    scan_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable wins over everything; a conversion cut short never publishes.
        if (!ena) begin
            state_d  = ST_IDLE;
            scan_d   = '0;
            code_d   = '0;
            res_d    = res_q;
            res_ch_d = res_ch_q;
        end
    end

    assign dac_code  = (state_q == ST_TRIAL || state_q == ST_DECIDE) ? trial : '0;
    assign ch_sel    = ch_q;
    assign sample    = (state_q == ST_SAMPLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result    = res_q;
    assign result_ch = res_ch_q;

endmodule
